// File: rtl/micro_seq_pkg.sv
// Shared opcodes and helpers for the micro-sequencer next-address engine.
package micro_seq_pkg;

   localparam int NS_OP_W = 3;

   localparam logic [NS_OP_W-1:0] NS_INC  = 3'd0;
   localparam logic [NS_OP_W-1:0] NS_JMP  = 3'd1;
   localparam logic [NS_OP_W-1:0] NS_CJMP = 3'd2;
   localparam logic [NS_OP_W-1:0] NS_DISP = 3'd3;
   localparam logic [NS_OP_W-1:0] NS_WAIT = 3'd4;
   localparam logic [NS_OP_W-1:0] NS_CALL = 3'd5;
   localparam logic [NS_OP_W-1:0] NS_RET  = 3'd6;
   localparam logic [NS_OP_W-1:0] NS_RST  = 3'd7;

   // Index width that never collapses to zero bits for single-entry ranges
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/micro_ret_stack.sv
// Micro-subroutine return-address stack. Push while full and pop while
// empty are ignored; the caller reports those as errors.
module micro_ret_stack
   import micro_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 6
)(
   input  logic         i_clk,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_clr,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PTR_W = $clog2(DEPTH + 1);
   localparam int IDX_W = clog2_min1(DEPTH);

   logic [PTR_W-1:0] r_sp;
   logic [W-1:0]     r_mem [DEPTH];
   logic [IDX_W-1:0] w_wr_idx;
   logic [IDX_W-1:0] w_rd_idx;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_sp == PTR_W'(DEPTH));
   assign o_empty   = (r_sp == '0);
   assign w_do_push = i_push & ~o_full & ~i_clr;
   assign w_do_pop  = i_pop & ~o_empty & ~i_clr;
   assign w_wr_idx  = IDX_W'(r_sp);
   assign w_rd_idx  = o_empty ? '0 : IDX_W'(r_sp - PTR_W'(1));
   assign o_dout    = r_mem[w_rd_idx];

   // Stack pointer: clear dominates, then push or pop
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_sp <= '0;
      end else if (w_do_push) begin
         r_sp <= r_sp + PTR_W'(1);
      end else if (w_do_pop) begin
         r_sp <= r_sp - PTR_W'(1);
      end
   end

   // Entry storage; contents above the pointer are don't-care, so no reset
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[w_wr_idx] <= i_din;
      end
   end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address engine driving the micro-PC of an asynchronous control ROM.
// Optional feature: define MICRO_SEQ_WAIT_TIMEOUT_EN to add a WAIT timeout
// that traps to TRAP_ADDR and raises the sticky o_wait_to flag.
module micro_sequencer
   import micro_seq_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int NCOND       = 4,
   parameter int STACK_DEPTH = 4,
   parameter int FETCH_ADDR  = 0,
`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
   parameter int TIMEOUT     = 16,
   parameter int TRAP_ADDR   = (1 << ADDR_W) - 1,
`endif
   parameter int CSEL_W      = clog2_min1(NCOND)
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clk_en,
   input  logic [NS_OP_W-1:0] i_ns_op,
   input  logic [CSEL_W-1:0]  i_cond_sel,
   input  logic               i_inv,
   input  logic [ADDR_W-1:0]  i_branch_addr,
   input  logic [ADDR_W-1:0]  i_dispatch_addr,
   input  logic [NCOND-1:0]   i_cond,
   input  logic               i_mfc,
   output logic [ADDR_W-1:0]  o_upc,
   output logic               o_waiting,
   output logic               o_stk_ovf,
`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
   output logic               o_stk_unf,
   output logic               o_wait_to
`else
   output logic               o_stk_unf
`endif
);

   logic [ADDR_W-1:0] r_upc;
   logic              r_ovf;
   logic              r_unf;

   logic              w_adv;
   logic              w_sel_bit;
   logic              w_ct;
   logic [ADDR_W-1:0] w_inc;
   logic [ADDR_W-1:0] w_next;
   logic              w_push;
   logic              w_pop;
   logic              w_clr_stk;
   logic              w_ovf_set;
   logic              w_unf_set;
   logic [ADDR_W-1:0] w_top;
   logic              w_full;
   logic              w_empty;
   logic              w_wait_stall;

   assign w_adv        = i_clk_en & ~i_rst;
   assign w_inc        = r_upc + ADDR_W'(1);
   assign w_ct         = w_sel_bit ^ i_inv;
   assign w_wait_stall = (i_ns_op == NS_WAIT) & ~i_mfc;
   assign o_waiting    = w_wait_stall;
   assign o_upc        = r_upc;
   assign o_stk_ovf    = r_ovf;
   assign o_stk_unf    = r_unf;

   // Condition select; indices beyond NCOND read as zero
   always_comb begin
      w_sel_bit = 1'b0;
      for (int i = 0; i < NCOND; i++) begin
         if (i_cond_sel == CSEL_W'(i)) begin
            w_sel_bit = i_cond[i];
         end
      end
   end

`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_wcnt;
   logic             r_wait_to;
   logic             w_trap;

   assign w_trap    = w_wait_stall & (r_wcnt == CNT_W'(TIMEOUT - 1));
   assign o_wait_to = r_wait_to;

   // Stall counter: runs only across consecutive stalled WAIT cycles
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wcnt    <= '0;
         r_wait_to <= 1'b0;
      end else if (i_clk_en) begin
         if (!w_wait_stall || w_trap) begin
            r_wcnt <= '0;
         end else begin
            r_wcnt <= r_wcnt + CNT_W'(1);
         end
         if (w_trap) begin
            r_wait_to <= 1'b1;
         end
      end
   end
`else
   logic w_trap;
   assign w_trap = 1'b0;
`endif

   // Next-address selection and stack/error side effects of the current op
   always_comb begin
      w_next    = w_inc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      case (i_ns_op)
         NS_INC:  w_next = w_inc;
         NS_JMP:  w_next = i_branch_addr;
         NS_CJMP: w_next = w_ct ? i_branch_addr : w_inc;
         NS_DISP: w_next = i_dispatch_addr;
         NS_WAIT: w_next = i_mfc ? w_inc : r_upc;
         NS_CALL: begin
            if (w_ct) begin
               w_next    = i_branch_addr;
               w_push    = ~w_full;
               w_ovf_set = w_full;
            end
         end
         NS_RET: begin
            if (w_empty) begin
               w_next    = ADDR_W'(FETCH_ADDR);
               w_unf_set = 1'b1;
            end else begin
               w_next = w_top;
               w_pop  = 1'b1;
            end
         end
         default: w_next = ADDR_W'(FETCH_ADDR);
      endcase
`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
      if (w_trap) begin
         w_next = ADDR_W'(TRAP_ADDR);
      end
`endif
   end

   assign w_clr_stk = i_rst | (w_adv & (i_ns_op == NS_RST));

   micro_ret_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (ADDR_W)
   ) u_stack (
      .i_clk   (i_clk),
      .i_push  (w_adv & w_push),
      .i_pop   (w_adv & w_pop),
      .i_clr   (w_clr_stk),
      .i_din   (w_inc),
      .o_dout  (w_top),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Micro-PC and sticky error flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_upc <= ADDR_W'(FETCH_ADDR);
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (i_clk_en) begin
         r_upc <= w_next;
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end
         if (w_unf_set) begin
            r_unf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomised bench for micro_sequencer with a queue-based reference model.
// Covers the WAIT timeout when MICRO_SEQ_WAIT_TIMEOUT_EN is defined.
module tb_micro_sequencer;
   import micro_seq_pkg::*;

   localparam int AW    = 6;
   localparam int NC    = 4;
   localparam int DEPTH = 4;
   localparam int FETCH = 0;
   localparam int TO    = 16;
   localparam int TRAP  = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          clk_en;
   logic [2:0]    ns_op;
   logic [1:0]    cond_sel;
   logic          inv;
   logic [AW-1:0] branch_addr;
   logic [AW-1:0] dispatch_addr;
   logic [NC-1:0] cond;
   logic          mfc;
   logic [AW-1:0] upc;
   logic          waiting;
   logic          stk_ovf;
   logic          stk_unf;
`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
   logic          wait_to;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state
   int m_upc = 0;
   int m_stk[$];
   bit m_ovf = 0;
   bit m_unf = 0;
   int m_wcnt = 0;
   bit m_wto = 0;

   always #5 clk = ~clk;

   micro_sequencer dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_clk_en        (clk_en),
      .i_ns_op         (ns_op),
      .i_cond_sel      (cond_sel),
      .i_inv           (inv),
      .i_branch_addr   (branch_addr),
      .i_dispatch_addr (dispatch_addr),
      .i_cond          (cond),
      .i_mfc           (mfc),
      .o_upc           (upc),
      .o_waiting       (waiting),
      .o_stk_ovf       (stk_ovf),
`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
      .o_stk_unf       (stk_unf),
      .o_wait_to       (wait_to)
`else
      .o_stk_unf       (stk_unf)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply the architectural rules for one clock edge to the model
   task automatic model_edge();
      bit ct;
      int inc;
      if (rst) begin
         m_upc = FETCH;
         m_stk.delete();
         m_ovf = 0;
         m_unf = 0;
         m_wcnt = 0;
         m_wto = 0;
      end else if (clk_en) begin
         ct  = ((int'(cond_sel) < NC) ? cond[cond_sel] : 1'b0) ^ inv;
         inc = (m_upc + 1) % (1 << AW);
         case (ns_op)
            NS_INC:  m_upc = inc;
            NS_JMP:  m_upc = int'(branch_addr);
            NS_CJMP: m_upc = ct ? int'(branch_addr) : inc;
            NS_DISP: m_upc = int'(dispatch_addr);
            NS_WAIT: m_upc = mfc ? inc : m_upc;
            NS_CALL: begin
               if (ct) begin
                  if (m_stk.size() < DEPTH) m_stk.push_back(inc);
                  else m_ovf = 1;
                  m_upc = int'(branch_addr);
               end else begin
                  m_upc = inc;
               end
            end
            NS_RET: begin
               if (m_stk.size() > 0) m_upc = m_stk.pop_back();
               else begin
                  m_unf = 1;
                  m_upc = FETCH;
               end
            end
            default: begin
               m_upc = FETCH;
               m_stk.delete();
            end
         endcase
`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
         if (ns_op == NS_WAIT && !mfc) begin
            if (m_wcnt == TO - 1) begin
               m_upc = TRAP;
               m_wto = 1;
               m_wcnt = 0;
            end else begin
               m_wcnt++;
            end
         end else begin
            m_wcnt = 0;
         end
`endif
      end
   endtask

   // One full cycle: drive, check combinational output, clock, check state
   task automatic cyc(input logic r, input logic en, input logic [2:0] op,
                      input logic [1:0] sel, input logic iv,
                      input logic [AW-1:0] ba, input logic [AW-1:0] da,
                      input logic [NC-1:0] c, input logic m);
      rst = r; clk_en = en; ns_op = op; cond_sel = sel; inv = iv;
      branch_addr = ba; dispatch_addr = da; cond = c; mfc = m;
      #1;
      chk("waiting", int'(waiting), int'(op == NS_WAIT && !m));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("upc", int'(upc), m_upc);
      chk("stk_ovf", int'(stk_ovf), int'(m_ovf));
      chk("stk_unf", int'(stk_unf), int'(m_unf));
`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
      chk("wait_to", int'(wait_to), int'(m_wto));
`endif
   endtask

   // Enabled op with the condition forced true (inv=1, cond=0)
   task automatic op1(input logic [2:0] op, input logic [AW-1:0] ba, input logic m);
      cyc(1'b0, 1'b1, op, 2'd0, 1'b1, ba, 6'd0, 4'd0, m);
   endtask

   task automatic do_rst();
      cyc(1'b1, 1'b1, NS_INC, 2'd0, 1'b0, 6'd0, 6'd0, 4'd0, 1'b0);
   endtask

   initial begin
      // Reset and increment
      do_rst();
      chk("rst_upc", int'(upc), 0);
      for (int i = 1; i <= 3; i++) begin
         op1(NS_INC, 6'd0, 1'b0);
         chk("inc_seq", int'(upc), i);
      end
      op1(NS_JMP, 6'd63, 1'b0);
      op1(NS_INC, 6'd0, 1'b0);
      chk("inc_wrap", int'(upc), 0);

      // Conditional jump with and without inversion
      op1(NS_JMP, 6'd8, 1'b0);
      cyc(1'b0, 1'b1, NS_CJMP, 2'd2, 1'b0, 6'h20, 6'd0, 4'b0100, 1'b0);
      chk("cjmp_taken", int'(upc), 'h20);
      cyc(1'b0, 1'b1, NS_CJMP, 2'd2, 1'b1, 6'h30, 6'd0, 4'b0100, 1'b0);
      chk("cjmp_inv", int'(upc), 'h21);

      // Dispatch
      cyc(1'b0, 1'b1, NS_DISP, 2'd0, 1'b0, 6'd0, 6'd45, 4'd0, 1'b0);
      chk("disp", int'(upc), 45);

      // WAIT stall and release
      op1(NS_JMP, 6'd5, 1'b0);
      for (int i = 0; i < 4; i++) op1(NS_WAIT, 6'd0, 1'b0);
      chk("wait_hold", int'(upc), 5);
      op1(NS_WAIT, 6'd0, 1'b1);
      chk("wait_rel", int'(upc), 6);

      // Nested CALL/RET
      op1(NS_JMP, 6'd3, 1'b0);
      op1(NS_CALL, 6'h10, 1'b0);
      op1(NS_CALL, 6'h18, 1'b0);
      op1(NS_RET, 6'd0, 1'b0);
      chk("ret_inner", int'(upc), 'h11);
      op1(NS_RET, 6'd0, 1'b0);
      chk("ret_outer", int'(upc), 4);

      // Overflow then drain to underflow
      op1(NS_JMP, 6'd0, 1'b0);
      for (int i = 1; i <= 5; i++) op1(NS_CALL, 6'(i * 10), 1'b0);
      chk("ovf_set", int'(stk_ovf), 1);
      chk("ovf_jump", int'(upc), 50);
      for (int i = 3; i >= 0; i--) begin
         op1(NS_RET, 6'd0, 1'b0);
         chk("ovf_ret", int'(upc), i * 10 + 1);
      end
      op1(NS_RET, 6'd0, 1'b0);
      chk("unf_upc", int'(upc), FETCH);
      chk("unf_set", int'(stk_unf), 1);
      do_rst();
      chk("rst_flags", int'(stk_ovf) + int'(stk_unf), 0);

      // clk_en low holds state
      op1(NS_JMP, 6'd12, 1'b0);
      cyc(1'b0, 1'b0, NS_JMP, 2'd0, 1'b0, 6'd40, 6'd0, 4'd0, 1'b0);
      chk("en_hold", int'(upc), 12);

      // RST op clears the stack but keeps error flags
      op1(NS_CALL, 6'd20, 1'b0);
      op1(NS_RST, 6'd0, 1'b0);
      op1(NS_RET, 6'd0, 1'b0);
      chk("rstop_unf", int'(stk_unf), 1);

      // Reset in the middle of a WAIT at depth 2
      do_rst();
      op1(NS_CALL, 6'd20, 1'b0);
      op1(NS_CALL, 6'd30, 1'b0);
      op1(NS_WAIT, 6'd0, 1'b0);
      cyc(1'b1, 1'b1, NS_WAIT, 2'd0, 1'b0, 6'd0, 6'd0, 4'd0, 1'b0);
      chk("rst_mid_upc", int'(upc), 0);
      op1(NS_RET, 6'd0, 1'b0);
      chk("rst_mid_unf", int'(stk_unf), 1);

`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
      do_rst();
      op1(NS_JMP, 6'd7, 1'b0);
      for (int i = 0; i < TO; i++) op1(NS_WAIT, 6'd0, 1'b0);
      chk("to_upc", int'(upc), TRAP);
      chk("to_flag", int'(wait_to), 1);
`endif

      // Randomised traffic against the model
      do_rst();
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
             ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
             3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             6'($urandom_range(0, 63)),
             6'($urandom_range(0, 63)),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised next-address engine for the microprogrammed ARM control path. It replaces the fixed 4-bit state register, incrementer, next-state-address selector and 4:1 address mux.
- Drives the micro-PC (upc) that indexes an external asynchronous control ROM. It consumes that ROM's next-state fields on the same cycle.
- Adds over the previous generation:
  - parametrised address width;
  - N selectable, invertible condition inputs;
  - instruction dispatch;
  - memory-function-complete (mfc) wait;
  - a micro-subroutine call/return stack.

Parameters:
- ADDR_W, 6, micro-PC / ROM address width.
- NCOND, 4, number of condition inputs (status flags, etc.).
- STACK_DEPTH, 4, return-stack entries (≥1).
- FETCH_ADDR, 0, address loaded on reset, on op RST, and on stack underflow.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- clk_en, in, 1, advance enable; when 0 all state holds.
- ns_op, in, 3, next-state opcode from the current microword.
- cond_sel, in, $clog2(NCOND), condition index from the microword.
- inv, in, 1, invert selected condition.
- branch_addr, in, ADDR_W, branch/call target from the microword.
- dispatch_addr, in, ADDR_W, IR-decoded entry address from the encoder.
- cond, in, NCOND, condition inputs.
- mfc, in, 1, memory function complete.
- upc, out, ADDR_W, current micro-PC.
- waiting, out, 1, high while a WAIT op is stalling on mfc.
- stk_ovf, out, 1, sticky overflow error.
- stk_unf, out, 1, sticky underflow error.

Behaviour:
- Clock and reset:
  - Single clock. All registers update on the rising edge of clk only when clk_en=1 or rst=1.
  - rst has priority over clk_en.
- Reset: upc=FETCH_ADDR, stack pointer=0 (empty), stk_ovf=0, stk_unf=0. This applies mid-WAIT or mid-subroutine as well; no pending push or pop survives.
- Condition term: ct = cond[cond_sel] ^ inv.
  - cond_sel ≥ NCOND reads as 0, so ct = inv.
- waiting is combinational: (ns_op==WAIT) & ~mfc.
- Next-address selection, one-cycle latency (upc' is registered). "+1" wraps modulo 2^ADDR_W:
  - 000 INC: upc+1.
  - 001 JMP: branch_addr.
  - 010 CJMP: ct ? branch_addr : upc+1.
  - 011 DISP: dispatch_addr.
  - 100 WAIT: mfc ? upc+1 : upc. mfc is sampled on the same edge, so there is zero extra latency when mfc is already high.
  - 101 CALL: if ct, push upc+1 and jump to branch_addr; else upc+1. An unconditional call uses inv=1 with an out-of-range or zero condition.
  - 110 RET: if the stack is non-empty, pop to upc; if empty, set stk_unf and load FETCH_ADDR.
  - 111 RST: FETCH_ADDR; the stack is cleared and error flags are kept.
- Stack overflow: a CALL with the stack full (STACK_DEPTH entries) sets stk_ovf. The push is dropped, the jump still occurs, and existing entries are preserved.
- Nesting: a return to an address popped off the stack works at any nesting depth. A push and a pop never occur on the same edge, because each op does at most one.
- Error flags: stk_ovf and stk_unf clear only on rst.
- clk_en=0: upc, the stack and the flags hold. waiting still reflects its inputs combinationally.

Optional Feature:
- Macro: MICRO_SEQ_WAIT_TIMEOUT_EN.
- When defined:
  - Adds parameters TIMEOUT (default 16) and TRAP_ADDR (default 2^ADDR_W-1), plus an output port wait_to (1, sticky).
  - A $clog2(TIMEOUT+1)-bit counter increments on each enabled cycle spent in WAIT with mfc=0. It clears when ns_op≠WAIT or when mfc=1.
  - When the counter reaches TIMEOUT-1 and mfc is still 0, the next upc is TRAP_ADDR, wait_to is set, and the counter clears.
  - If mfc=1 on the same edge, mfc wins and there is no trap.
  - wait_to and the counter clear on rst.
- When undefined: WAIT stalls indefinitely, and neither the port nor the counter exists.

Decomposition:
- Package micro_seq_pkg:
  - ns_op localparams: NS_INC, NS_JMP, NS_CJMP, NS_DISP, NS_WAIT, NS_CALL, NS_RET, NS_RST.
  - NS_OP_W=3.
- Sub-module micro_ret_stack (params DEPTH, W):
  - Ports: push, pop, clr, din, dout, full, empty.
  - Synchronous; ignores push when full and pop when empty.

Test Plan:
- Reset/INC: rst=1 for one edge, then ns_op=INC for 3 edges → upc 0,1,2,3. With ADDR_W=6 and upc=63, INC → 0.
- CJMP/inv: cond=4'b0100, cond_sel=2, branch_addr=0x20, inv=0 → upc=0x20. Same with inv=1 → upc+1.
- WAIT: at upc=5, ns_op=WAIT, mfc=0 for 4 edges → upc stays 5 and waiting=1. Then mfc=1 → upc=6, waiting=0.
- CALL/RET nesting: from upc=3, CALL to 0x10; from 0x10, CALL to 0x18; RET → 0x11; RET → 4. stk_* stay 0.
- Overflow/underflow: 5 CALLs with STACK_DEPTH=4 → stk_ovf=1 after the 5th, and 4 RETs return the first 4 pushed addresses. A 5th RET → upc=FETCH_ADDR, stk_unf=1. rst clears both flags.
- clk_en/reset-mid-op: clk_en=0 during JMP → upc unchanged. rst asserted during WAIT at depth 2 → upc=0 and stack empty (a following RET sets stk_unf). With MICRO_SEQ_WAIT_TIMEOUT_EN and TIMEOUT=16: mfc low for 16 cycles → upc=TRAP_ADDR and wait_to=1.
